// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between the CPU and one DMA requester.
// Fixed CPU priority, DMA starvation override, registered grant/response and per-access timeout.
module lc3_mem_arbiter #(
    parameter int unsigned DMA_MAX_LOSS = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_rdy,
    output logic        mem_err,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DONE} arbStateT;

    localparam logic [7:0] LOSS_LIMIT = 8'(DMA_MAX_LOSS);
    localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT);

    arbStateT    stateReg, stateNext;
    logic [7:0]  lossCntReg, lossCntNext;
    logic [7:0]  toCntReg, toCntNext;
    logic        memEnReg, memEnNext;
    logic        memWeReg, memWeNext;
    logic [15:0] memAddrReg, memAddrNext;
    logic [15:0] memDinReg, memDinNext;
    logic [15:0] cpuRdataReg, cpuRdataNext;
    logic        cpuRdyReg, cpuRdyNext;
    logic [15:0] dmaRdataReg, dmaRdataNext;
    logic        dmaAckReg, dmaAckNext;
    logic        memErrReg, memErrNext;
    logic [1:0]  ownerReg, ownerNext;

    logic        grantDma;
    logic [7:0]  toInc;
    logic [15:0] respData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            lossCntReg  <= 8'd0;
            toCntReg    <= 8'd0;
            memEnReg    <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= 16'h0000;
            memDinReg   <= 16'h0000;
            cpuRdataReg <= 16'h0000;
            cpuRdyReg   <= 1'b0;
            dmaRdataReg <= 16'h0000;
            dmaAckReg   <= 1'b0;
            memErrReg   <= 1'b0;
            ownerReg    <= 2'b00;
        end else begin
            stateReg    <= stateNext;
            lossCntReg  <= lossCntNext;
            toCntReg    <= toCntNext;
            memEnReg    <= memEnNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memDinReg   <= memDinNext;
            cpuRdataReg <= cpuRdataNext;
            cpuRdyReg   <= cpuRdyNext;
            dmaRdataReg <= dmaRdataNext;
            dmaAckReg   <= dmaAckNext;
            memErrReg   <= memErrNext;
            ownerReg    <= ownerNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        lossCntNext  = lossCntReg;
        toCntNext    = toCntReg;
        memEnNext    = memEnReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memDinNext   = memDinReg;
        ownerNext    = ownerReg;
        // Response signals are single-cycle: they fall back to zero unless set below.
        cpuRdataNext = 16'h0000;
        cpuRdyNext   = 1'b0;
        dmaRdataNext = 16'h0000;
        dmaAckNext   = 1'b0;
        memErrNext   = 1'b0;

        grantDma = dma_req && (!cpu_en || (lossCntReg >= LOSS_LIMIT));
        toInc    = toCntReg + 8'd1;
        respData = (mem_rdy && !memWeReg) ? mem_dout : 16'h0000;

        case (stateReg)
            IDLE: begin
                if (cpu_en || dma_req) begin
                    toCntNext = 8'd0;
                    memEnNext = 1'b1;
                    if (grantDma) begin
                        stateNext   = DMA_ACC;
                        ownerNext   = 2'b10;
                        memWeNext   = dma_we;
                        memAddrNext = dma_addr;
                        memDinNext  = dma_wdata;
                        lossCntNext = 8'd0;
                    end else begin
                        stateNext   = CPU_ACC;
                        ownerNext   = 2'b01;
                        memWeNext   = cpu_we;
                        memAddrNext = cpu_addr;
                        memDinNext  = cpu_wdata;
                        if (dma_req && (lossCntReg != 8'hFF)) begin
                            lossCntNext = lossCntReg + 8'd1;
                        end
                    end
                end
            end
            CPU_ACC, DMA_ACC: begin
                // mem_rdy takes precedence over a timeout landing on the same cycle.
                if (mem_rdy || (toInc == TO_LIMIT)) begin
                    stateNext   = DONE;
                    memEnNext   = 1'b0;
                    memWeNext   = 1'b0;
                    memAddrNext = 16'h0000;
                    memDinNext  = 16'h0000;
                    ownerNext   = 2'b00;
                    memErrNext  = !mem_rdy;
                    if (stateReg == CPU_ACC) begin
                        cpuRdyNext   = 1'b1;
                        cpuRdataNext = respData;
                    end else begin
                        dmaAckNext   = 1'b1;
                        dmaRdataNext = respData;
                    end
                end else begin
                    toCntNext = toInc;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign mem_en    = memEnReg;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_din   = memDinReg;
    assign cpu_rdata = cpuRdataReg;
    assign cpu_rdy   = cpuRdyReg;
    assign dma_rdata = dmaRdataReg;
    assign dma_ack   = dmaAckReg;
    assign mem_err   = memErrReg;
    assign owner     = ownerReg;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration and memory contents.
module tb_lc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_en = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
    logic [15:0] cpu_rdata;
    logic        cpu_rdy;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0, dma_wdata = 16'h0;
    logic [15:0] dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_din;
    logic [15:0] mem_dout = 16'h0;
    logic        mem_rdy = 1'b0;
    logic        mem_err;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;

    lc3_mem_arbiter #(.DMA_MAX_LOSS(2), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_rdy(mem_rdy), .mem_err(mem_err), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        cpu_en = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdy = 0; mem_dout = 0;
    endtask

    task automatic reset_pulse;
        @(negedge clk);
        rst = 0;
        clear_inputs();
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_reset;
        logic [83:0] allOut;
        clear_inputs();
        #1;
        allOut = {cpu_rdata, cpu_rdy, dma_rdata, dma_ack, mem_en, mem_we, mem_addr, mem_din, mem_err, owner};
        checks++;
        if (allOut !== 84'h0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", allOut); end
        @(negedge clk); rst = 1;
        tick();
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h3000;
        tick();
        checks++;
        if (mem_en !== 1'b1) begin failures++; $display("FAIL reset_pre_acc: mem_en=%b expected 1", mem_en); end
        #2 rst = 0;
        #1;
        allOut = {cpu_rdata, cpu_rdy, dma_rdata, dma_ack, mem_en, mem_we, mem_addr, mem_din, mem_err, owner};
        checks++;
        if (allOut !== 84'h0) begin failures++; $display("FAIL reset_async: got %h expected 0", allOut); end
        cpu_en = 0; mem_rdy = 1; mem_dout = 16'h7777;
        @(negedge clk); rst = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cpu_rdy !== 1'b0 || mem_en !== 1'b0)
                begin failures++; $display("FAIL reset_no_rdy: cpu_rdy=%b mem_en=%b expected 0 0", cpu_rdy, mem_en); end
        end
        mem_rdy = 0;
        $display("txn reset: done");
    endtask

    task automatic test_cpu_read;
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
        tick();                                   // cycle 1
        checks++;
        if ({mem_en, mem_addr, owner, cpu_rdy} !== {1'b1, 16'h3000, 2'b01, 1'b0})
            begin failures++; $display("FAIL cpu_read_c1: en=%b addr=%h owner=%b rdy=%b expected 1 3000 01 0", mem_en, mem_addr, owner, cpu_rdy); end
        tick();                                   // cycle 2
        checks++;
        if ({mem_en, mem_addr, owner, cpu_rdy} !== {1'b1, 16'h3000, 2'b01, 1'b0})
            begin failures++; $display("FAIL cpu_read_c2: en=%b addr=%h owner=%b rdy=%b expected 1 3000 01 0", mem_en, mem_addr, owner, cpu_rdy); end
        mem_rdy = 1; mem_dout = 16'h1234;
        tick();                                   // cycle 3
        checks++;
        if ({cpu_rdy, cpu_rdata, mem_en, owner, dma_ack} !== {1'b1, 16'h1234, 1'b0, 2'b00, 1'b0})
            begin failures++; $display("FAIL cpu_read_c3: rdy=%b rdata=%h en=%b owner=%b ack=%b expected 1 1234 0 00 0", cpu_rdy, cpu_rdata, mem_en, owner, dma_ack); end
        mem_rdy = 0; cpu_en = 0;
        tick();                                   // cycle 4
        checks++;
        if ({cpu_rdy, cpu_rdata} !== {1'b0, 16'h0})
            begin failures++; $display("FAIL cpu_read_c4: rdy=%b rdata=%h expected 0 0000", cpu_rdy, cpu_rdata); end
        $display("txn cpu_read: addr=3000");
    endtask

    task automatic test_dma_write;
        dma_req = 1; dma_we = 1; dma_addr = 16'h4000; dma_wdata = 16'hBEEF;
        tick();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_din, owner} !== {1'b1, 1'b1, 16'h4000, 16'hBEEF, 2'b10})
            begin failures++; $display("FAIL dma_write_acc: en=%b we=%b addr=%h din=%h owner=%b expected 1 1 4000 beef 10", mem_en, mem_we, mem_addr, mem_din, owner); end
        mem_rdy = 1; mem_dout = 16'h5555;
        tick();
        checks++;
        if ({dma_ack, dma_rdata, cpu_rdy, mem_err} !== {1'b1, 16'h0, 1'b0, 1'b0})
            begin failures++; $display("FAIL dma_write_done: ack=%b rdata=%h cpu_rdy=%b err=%b expected 1 0000 0 0", dma_ack, dma_rdata, cpu_rdy, mem_err); end
        mem_rdy = 0; dma_req = 0;
        tick();
        checks++;
        if (dma_ack !== 1'b0) begin failures++; $display("FAIL dma_write_pulse: ack=%b expected 0", dma_ack); end
        $display("txn dma_write: addr=4000 data=beef");
    endtask

    task automatic test_starvation;
        logic [1:0] expOrder [6];
        expOrder = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        reset_pulse();
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h1000;
        dma_req = 1; dma_we = 1; dma_addr = 16'h2000; dma_wdata = 16'hA5A5;
        for (int g = 0; g < 6; g++) begin
            tick();
            checks++;
            if (owner !== expOrder[g]) begin failures++; $display("FAIL starve_grant%0d: owner=%b expected %b", g, owner, expOrder[g]); end
            mem_rdy = 1; mem_dout = 16'($urandom);
            tick();
            checks++;
            if ({cpu_rdy, dma_ack} !== {expOrder[g] == 2'b01, expOrder[g] == 2'b10})
                begin failures++; $display("FAIL starve_ack%0d: cpu_rdy=%b dma_ack=%b owner_expected=%b", g, cpu_rdy, dma_ack, expOrder[g]); end
            mem_rdy = 0;
            tick();
            $display("txn starve %0d: owner=%b", g, expOrder[g]);
        end
        clear_inputs();
    endtask

    task automatic test_timeout;
        int n;
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h3100; mem_dout = 16'hDEAD; mem_rdy = 0;
        tick();
        n = 0;
        while (mem_en === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 255) begin failures++; $display("FAIL timeout_len: mem_en cycles=%0d expected 255", n); end
        checks++;
        if ({cpu_rdy, cpu_rdata, mem_err} !== {1'b1, 16'h0, 1'b1})
            begin failures++; $display("FAIL timeout_done: rdy=%b rdata=%h err=%b expected 1 0000 1", cpu_rdy, cpu_rdata, mem_err); end
        cpu_en = 0;
        tick();
        checks++;
        if ({mem_err, cpu_rdy} !== 2'b00) begin failures++; $display("FAIL timeout_pulse: err=%b rdy=%b expected 0 0", mem_err, cpu_rdy); end
        $display("txn timeout: cycles=%0d", n);
    endtask

    task automatic test_tie;
        int n;
        cpu_en = 1; cpu_we = 0; cpu_addr = 16'h3200; mem_rdy = 0;
        tick();
        n = 0;
        for (int c = 1; c < 255; c++) begin
            if (mem_en === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== 254 || mem_en !== 1'b1) begin failures++; $display("FAIL tie_hold: en_cycles=%0d en=%b expected 254 1", n, mem_en); end
        mem_rdy = 1; mem_dout = 16'hABCD;
        tick();
        checks++;
        if ({cpu_rdy, cpu_rdata, mem_err} !== {1'b1, 16'hABCD, 1'b0})
            begin failures++; $display("FAIL tie_done: rdy=%b rdata=%h err=%b expected 1 abcd 0", cpu_rdy, cpu_rdata, mem_err); end
        cpu_en = 0; mem_rdy = 0;
        tick();
        mem_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cpu_rdy, dma_ack, mem_en, owner, mem_err} !== 6'b0)
                begin failures++; $display("FAIL stray_rdy: rdy=%b ack=%b en=%b owner=%b err=%b expected all 0", cpu_rdy, dma_ack, mem_en, owner, mem_err); end
        end
        mem_rdy = 0;
        $display("txn tie: done");
    endtask

    task automatic test_random;
        logic [15:0] memModel [256];
        logic        cpuOn, cpuWr, dmaOn, dmaWr, dmaWins, expWe;
        logic [15:0] cpuA, cpuD, dmaA, dmaD, expA, expD, expRd;
        int          lossModel, lat;
        reset_pulse();
        for (int i = 0; i < 256; i++) memModel[i] = 16'($urandom);
        cpuOn = 0; dmaOn = 0; lossModel = 0;
        cpuWr = 0; dmaWr = 0; cpuA = 0; cpuD = 0; dmaA = 0; dmaD = 0;
        for (int t = 0; t < 60; t++) begin
            if (!cpuOn && $urandom_range(0, 2) != 0) begin
                cpuOn = 1; cpuWr = 1'($urandom); cpuA = 16'($urandom); cpuD = 16'($urandom);
            end
            if (!dmaOn && $urandom_range(0, 2) != 0) begin
                dmaOn = 1; dmaWr = 1'($urandom); dmaA = 16'($urandom); dmaD = 16'($urandom);
            end
            cpu_en = cpuOn; cpu_we = cpuWr; cpu_addr = cpuA; cpu_wdata = cpuD;
            dma_req = dmaOn; dma_we = dmaWr; dma_addr = dmaA; dma_wdata = dmaD;
            if (!cpuOn && !dmaOn) begin
                mem_rdy = 1'($urandom);
                tick();
                checks++;
                if ({mem_en, owner, cpu_rdy, dma_ack} !== 5'b0)
                    begin failures++; $display("FAIL rand_idle%0d: en=%b owner=%b rdy=%b ack=%b expected 0", t, mem_en, owner, cpu_rdy, dma_ack); end
                mem_rdy = 0;
                $display("txn rand %0d: idle", t);
                continue;
            end
            dmaWins = dmaOn && (!cpuOn || lossModel >= 2);
            if (dmaWins) lossModel = 0;
            else if (dmaOn) lossModel++;
            expWe = dmaWins ? dmaWr : cpuWr;
            expA  = dmaWins ? dmaA : cpuA;
            expD  = dmaWins ? dmaD : cpuD;
            tick();
            checks++;
            if ({mem_en, owner, mem_we, mem_addr, mem_din} !== {1'b1, dmaWins ? 2'b10 : 2'b01, expWe, expA, expD})
                begin failures++; $display("FAIL rand_grant%0d: en=%b owner=%b we=%b addr=%h din=%h expected 1 %b %b %h %h", t, mem_en, owner, mem_we, mem_addr, mem_din, dmaWins ? 2'b10 : 2'b01, expWe, expA, expD); end
            lat = $urandom_range(1, 4);
            for (int c = 1; c < lat; c++) begin
                mem_rdy = 0;
                tick();
                checks++;
                if ({mem_en, mem_addr} !== {1'b1, expA}) begin failures++; $display("FAIL rand_hold%0d: en=%b addr=%h expected 1 %h", t, mem_en, mem_addr, expA); end
            end
            mem_rdy = 1;
            if (expWe) begin
                mem_dout = 16'($urandom);
                expRd = 16'h0;
                memModel[expA[7:0]] = expD;
            end else begin
                mem_dout = memModel[expA[7:0]];
                expRd = memModel[expA[7:0]];
            end
            tick();
            checks++;
            if ({cpu_rdy, dma_ack, cpu_rdata, dma_rdata, mem_err, mem_en} !==
                {!dmaWins, dmaWins, dmaWins ? 16'h0 : expRd, dmaWins ? expRd : 16'h0, 1'b0, 1'b0})
                begin failures++; $display("FAIL rand_done%0d: rdy=%b ack=%b crd=%h drd=%h err=%b en=%b expected dma=%b rd=%h", t, cpu_rdy, dma_ack, cpu_rdata, dma_rdata, mem_err, mem_en, dmaWins, expRd); end
            if (dmaWins) begin dmaOn = 0; dma_req = 0; end
            else begin cpuOn = 0; cpu_en = 0; end
            mem_rdy = 0;
            tick();
            $display("txn rand %0d: owner=%s we=%b addr=%h lat=%0d", t, dmaWins ? "dma" : "cpu", expWe, expA, lat);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_starvation();
        test_timeout();
        test_tie();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 memory port (mem_en/mem_we/mem_rdy handshake) between the CPU memory interface and one DMA requester.
- Sits between the lc3 top-level memory pins and the external memory.
- Fixed CPU priority with a DMA anti-starvation override.
- Registered grant and registered response; per-access timeout so a hung memory cannot lock the processor.

Parameters:
- DMA_MAX_LOSS, 2, arbitration losses DMA tolerates before it is forced to win the next arbitration.
- TIMEOUT, 255, ACC-state cycles without mem_rdy before the access is aborted (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_en  in  1  CPU access request; held until cpu_rdy
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  16  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data; valid while cpu_rdy=1
- cpu_rdy  out  1  one-cycle CPU completion pulse
- dma_req  in  1  DMA access request; held until dma_ack
- dma_we  in  1  DMA write/read
- dma_addr  in  16  DMA address
- dma_wdata  in  16  DMA write data
- dma_rdata  out  16  DMA read data; valid while dma_ack=1
- dma_ack  out  1  one-cycle DMA completion pulse
- mem_en  out  1  memory enable, held for the whole access
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_din  out  16  memory write data
- mem_dout  in  16  memory read data
- mem_rdy  in  1  memory access complete
- mem_err  out  1  one-cycle pulse on timeout abort
- owner  out  2  current owner: 00 none, 01 CPU, 10 DMA

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - All outputs 0: data buses 16'h0000, owner 00.
  - Loss counter and timeout counter cleared.
  - Reset mid-access drops mem_en immediately. No ack or rdy is issued for the aborted access.
- State IDLE (arbitration):
  - No request: remain IDLE.
  - cpu_en only: grant CPU. dma_req only: grant DMA.
  - Both requesting: DMA wins if loss_cnt >= DMA_MAX_LOSS, otherwise CPU wins and loss_cnt increments (saturating).
  - loss_cnt clears whenever DMA is granted.
  - On a grant, the winner's we/addr/wdata are latched into the mem_* output registers, the timeout counter is cleared, and the block goes to CPU_ACC or DMA_ACC.
- States CPU_ACC / DMA_ACC:
  - mem_en=1, owner=01/10.
  - mem_we, mem_addr and mem_din stay stable from the latched values; requester inputs are ignored.
  - mem_rdy=1 sampled: capture mem_dout into the winner's rdata register (reads only; writes leave rdata at 0), then go to DONE.
  - Otherwise the timeout counter increments. When it equals TIMEOUT: go to DONE with rdata=16'h0000 and mem_err=1 for that DONE cycle.
- State DONE:
  - mem_en=0 and owner=00.
  - The winner's rdy/ack is 1 for exactly this cycle; the other requester sees nothing.
  - No arbitration happens in DONE. This lets the requester drop or change its request.
  - Next state is IDLE.
- rdata hold rule: rdata is 0 outside the DONE cycle.
- Latency:
  - Request sampled in IDLE at cycle 0; mem_en high from cycle 1.
  - If mem_rdy is sampled at cycle k (k>=1), the ack/rdy pulse is at cycle k+1 and IDLE is at k+2.
  - Minimum turnaround: 3 cycles per access, back-to-back.
- Requester rule: a request still asserted in the IDLE cycle after DONE is treated as a new access.
- mem_rdy asserted outside the ACC states is ignored.
- mem_rdy and timeout in the same cycle: mem_rdy wins and there is no mem_err.

Test Plan:
- Reset: drive rst=0 during CPU_ACC. Required: mem_en drops to 0 asynchronously, all outputs 0, and cpu_rdy never pulses after release.
- CPU read: cpu_en=1, cpu_we=0, cpu_addr=16'h3000; memory returns 16'h1234 with mem_rdy at the 2nd ACC cycle. Required: mem_en high cycles 1-2 with mem_addr=16'h3000; cpu_rdy=1 and cpu_rdata=16'h1234 at cycle 3 only; owner=01 during ACC.
- DMA write: dma_req=1, dma_we=1, addr 16'h4000, data 16'hBEEF; mem_rdy at 1st ACC cycle. Required: mem_we=1, mem_din=16'hBEEF; dma_ack one cycle; dma_rdata=0.
- Starvation: cpu_en and dma_req held high continuously, DMA_MAX_LOSS=2. Required grant order CPU, CPU, DMA, CPU, CPU, DMA; each ack goes only to its owner.
- Timeout: CPU read with mem_rdy never asserted, TIMEOUT=255. Required: mem_en high for exactly 255 cycles, then cpu_rdy=1 with cpu_rdata=16'h0000 and mem_err=1 in the same cycle.
- Tie: mem_rdy=1 on the 255th ACC cycle. Required: normal completion with mem_err=0. Also drive a stray mem_rdy pulse in IDLE. Required: no rdy/ack and no state change.
